// File: rtl/mips_ctrl.sv
// MIPS-subset instruction decoder: one strobe per recognised mnemonic plus the
// SPECIAL class flag R. Purely combinational by default; defining the macro
// MIPS_CTRL_REG_EN registers every output (1-cycle latency, synchronous reset).
module mips_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] I,
  output logic        R,
  output logic        lb, lbu, lh, lhu, lw,
  output logic        sb, sh, sw,
  output logic        add, addu, sub, subu, slt, sltu,
  output logic        and_, or_, xor_, nor_,
  output logic        sll, srl, sra, sllv, srlv, srav,
  output logic        mult, multu, div, divu,
  output logic        mfhi, mflo, mthi, mtlo,
  output logic        addi, addiu, andi, ori, xori, lui, slti, sltiu,
  output logic        beq, bne, blez, bgtz, bltz, bgez,
  output logic        j, jal, jalr, jr,
  output logic        eret, mfc0, mtc0
);

  // Field order here must match the output concatenation at the bottom.
  typedef struct packed {
    logic r;
    logic lb, lbu, lh, lhu, lw;
    logic sb, sh, sw;
    logic add, addu, sub, subu, slt, sltu;
    logic and_, or_, xor_, nor_;
    logic sll, srl, sra, sllv, srlv, srav;
    logic mult, multu, div, divu;
    logic mfhi, mflo, mthi, mtlo;
    logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
    logic beq, bne, blez, bgtz, bltz, bgez;
    logic j, jal, jalr, jr;
    logic eret, mfc0, mtc0;
  } dec_t;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] fn;
  dec_t       dec_p0;
  dec_t       dec_out;

  assign op = I[31:26];
  assign rs = I[25:21];
  assign rt = I[20:16];
  assign fn = I[5:0];

  // Stage p0: decode the instruction word into a one-hot strobe set.
  // Decode opcode classes first, then the sub-field (funct / rt / rs) inside each.
  always_comb begin
    dec_p0 = '0;
    case (op)
      6'h00: begin
        dec_p0.r = 1'b1;
        case (fn)
          6'h00: dec_p0.sll   = 1'b1;
          6'h02: dec_p0.srl   = 1'b1;
          6'h03: dec_p0.sra   = 1'b1;
          6'h04: dec_p0.sllv  = 1'b1;
          6'h06: dec_p0.srlv  = 1'b1;
          6'h07: dec_p0.srav  = 1'b1;
          6'h08: dec_p0.jr    = 1'b1;
          6'h09: dec_p0.jalr  = 1'b1;
          6'h10: dec_p0.mfhi  = 1'b1;
          6'h11: dec_p0.mthi  = 1'b1;
          6'h12: dec_p0.mflo  = 1'b1;
          6'h13: dec_p0.mtlo  = 1'b1;
          6'h18: dec_p0.mult  = 1'b1;
          6'h19: dec_p0.multu = 1'b1;
          6'h1A: dec_p0.div   = 1'b1;
          6'h1B: dec_p0.divu  = 1'b1;
          6'h20: dec_p0.add   = 1'b1;
          6'h21: dec_p0.addu  = 1'b1;
          6'h22: dec_p0.sub   = 1'b1;
          6'h23: dec_p0.subu  = 1'b1;
          6'h24: dec_p0.and_  = 1'b1;
          6'h25: dec_p0.or_   = 1'b1;
          6'h26: dec_p0.xor_  = 1'b1;
          6'h27: dec_p0.nor_  = 1'b1;
          6'h2A: dec_p0.slt   = 1'b1;
          6'h2B: dec_p0.sltu  = 1'b1;
          default: ;
        endcase
      end
      6'h01: begin
        // REGIMM: only rt=0/1 are implemented; the linking variants fall to RI.
        dec_p0.bltz = (rt == 5'h00);
        dec_p0.bgez = (rt == 5'h01);
      end
      6'h02: dec_p0.j     = 1'b1;
      6'h03: dec_p0.jal   = 1'b1;
      6'h04: dec_p0.beq   = 1'b1;
      6'h05: dec_p0.bne   = 1'b1;
      6'h06: dec_p0.blez  = 1'b1;
      6'h07: dec_p0.bgtz  = 1'b1;
      6'h08: dec_p0.addi  = 1'b1;
      6'h09: dec_p0.addiu = 1'b1;
      6'h0A: dec_p0.slti  = 1'b1;
      6'h0B: dec_p0.sltiu = 1'b1;
      6'h0C: dec_p0.andi  = 1'b1;
      6'h0D: dec_p0.ori   = 1'b1;
      6'h0E: dec_p0.xori  = 1'b1;
      6'h0F: dec_p0.lui   = 1'b1;
      6'h10: begin
        // eret is matched on the full word; its rs (0x10) never aliases mfc0/mtc0.
        dec_p0.mfc0 = (rs == 5'h00);
        dec_p0.mtc0 = (rs == 5'h04);
        dec_p0.eret = (I == ERET_WORD);
      end
      6'h20: dec_p0.lb    = 1'b1;
      6'h21: dec_p0.lh    = 1'b1;
      6'h23: dec_p0.lw    = 1'b1;
      6'h24: dec_p0.lbu   = 1'b1;
      6'h25: dec_p0.lhu   = 1'b1;
      6'h28: dec_p0.sb    = 1'b1;
      6'h29: dec_p0.sh    = 1'b1;
      6'h2B: dec_p0.sw    = 1'b1;
      default: ;
    endcase
  end

`ifdef MIPS_CTRL_REG_EN
  // Stage p1: registered strobes; power-up and reset both give all zeros.
  dec_t dec_p1 = '0;

  // Register the decode; reset wins over the incoming instruction.
  always_ff @(posedge clk) begin
    if (reset) dec_p1 <= '0;
    else       dec_p1 <= dec_p0;
  end

  assign dec_out = dec_p1;
`else
  // Combinational build: clock and reset are intentionally unconnected.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
  assign dec_out = dec_p0;
`endif

  assign {R,
          lb, lbu, lh, lhu, lw,
          sb, sh, sw,
          add, addu, sub, subu, slt, sltu,
          and_, or_, xor_, nor_,
          sll, srl, sra, sllv, srlv, srav,
          mult, multu, div, divu,
          mfhi, mflo, mthi, mtlo,
          addi, addiu, andi, ori, xori, lui, slti, sltiu,
          beq, bne, blez, bgtz, bltz, bgez,
          j, jal, jalr, jr,
          eret, mfc0, mtc0} = dec_out;

endmodule

// File: tb/tb_mips_ctrl.sv
// Self-checking bench for mips_ctrl: directed vectors with hand-written
// expectations plus randomized words checked against a table-driven model.
module tb_mips_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] I;
  logic R;
  logic lb, lbu, lh, lhu, lw, sb, sh, sw;
  logic add, addu, sub, subu, slt, sltu, and_, or_, xor_, nor_;
  logic sll, srl, sra, sllv, srlv, srav, mult, multu, div, divu;
  logic mfhi, mflo, mthi, mtlo;
  logic addi, addiu, andi, ori, xori, lui, slti, sltiu;
  logic beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr, eret, mfc0, mtc0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_ctrl dut (
    .clk(clk), .reset(reset), .I(I), .R(R),
    .lb(lb), .lbu(lbu), .lh(lh), .lhu(lhu), .lw(lw),
    .sb(sb), .sh(sh), .sw(sw),
    .add(add), .addu(addu), .sub(sub), .subu(subu), .slt(slt), .sltu(sltu),
    .and_(and_), .or_(or_), .xor_(xor_), .nor_(nor_),
    .sll(sll), .srl(srl), .sra(sra), .sllv(sllv), .srlv(srlv), .srav(srav),
    .mult(mult), .multu(multu), .div(div), .divu(divu),
    .mfhi(mfhi), .mflo(mflo), .mthi(mthi), .mtlo(mtlo),
    .addi(addi), .addiu(addiu), .andi(andi), .ori(ori), .xori(xori),
    .lui(lui), .slti(slti), .sltiu(sltiu),
    .beq(beq), .bne(bne), .blez(blez), .bgtz(bgtz), .bltz(bltz), .bgez(bgez),
    .j(j), .jal(jal), .jalr(jalr), .jr(jr),
    .eret(eret), .mfc0(mfc0), .mtc0(mtc0)
  );

  // Observed outputs: bit 53 is R, then strobes in the order of names[] below.
  logic [53:0] got;
  assign got = {R, lb, lbu, lh, lhu, lw, sb, sh, sw,
                add, addu, sub, subu, slt, sltu, and_, or_, xor_, nor_,
                sll, srl, sra, sllv, srlv, srav, mult, multu, div, divu,
                mfhi, mflo, mthi, mtlo,
                addi, addiu, andi, ori, xori, lui, slti, sltiu,
                beq, bne, blez, bgtz, bltz, bgez, j, jal, jalr, jr,
                eret, mfc0, mtc0};

  string names [53] = '{"lb","lbu","lh","lhu","lw","sb","sh","sw",
    "add","addu","sub","subu","slt","sltu","and_","or_","xor_","nor_",
    "sll","srl","sra","sllv","srlv","srav","mult","multu","div","divu",
    "mfhi","mflo","mthi","mtlo",
    "addi","addiu","andi","ori","xori","lui","slti","sltiu",
    "beq","bne","blez","bgtz","bltz","bgez","j","jal","jalr","jr",
    "eret","mfc0","mtc0"};

  // Opcode-only mnemonics and SPECIAL funct mnemonics, straight from the ISA tables.
  string      op_nm   [22] = '{"j","jal","beq","bne","blez","bgtz","addi","addiu",
    "slti","sltiu","andi","ori","xori","lui","lb","lh","lw","lbu","lhu","sb","sh","sw"};
  logic [5:0] op_code [22] = '{6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08,6'h09,
    6'h0A,6'h0B,6'h0C,6'h0D,6'h0E,6'h0F,6'h20,6'h21,6'h23,6'h24,6'h25,6'h28,6'h29,6'h2B};
  string      sp_nm   [26] = '{"sll","srl","sra","sllv","srlv","srav","jr","jalr",
    "mfhi","mthi","mflo","mtlo","mult","multu","div","divu","add","addu","sub","subu",
    "and_","or_","xor_","nor_","slt","sltu"};
  logic [5:0] sp_fn   [26] = '{6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,6'h08,6'h09,
    6'h10,6'h11,6'h12,6'h13,6'h18,6'h19,6'h1A,6'h1B,6'h20,6'h21,6'h22,6'h23,
    6'h24,6'h25,6'h26,6'h27,6'h2A,6'h2B};

  // Expected output vector from an R flag and a mnemonic name ("" = none).
  function automatic logic [53:0] expect_vec(input logic r, input string nm);
    logic [53:0] v;
    v = '0;
    v[53] = r;
    for (int i = 0; i < 53; i++)
      if (names[i] == nm) v[52-i] = 1'b1;
    return v;
  endfunction

  // Reference decoder: look the word up in the mnemonic tables.
  function automatic logic [53:0] model(input logic [31:0] ins);
    string nm;
    logic  r;
    nm = "";
    r  = 1'b0;
    if (ins[31:26] == 6'h00) begin
      r = 1'b1;
      for (int i = 0; i < 26; i++) if (sp_fn[i] == ins[5:0]) nm = sp_nm[i];
    end else if (ins[31:26] == 6'h01) begin
      if (ins[20:16] == 5'd0) nm = "bltz";
      if (ins[20:16] == 5'd1) nm = "bgez";
    end else if (ins[31:26] == 6'h10) begin
      if (ins == 32'h42000018)     nm = "eret";
      else if (ins[25:21] == 5'd0) nm = "mfc0";
      else if (ins[25:21] == 5'd4) nm = "mtc0";
    end else begin
      for (int i = 0; i < 22; i++) if (op_code[i] == ins[31:26]) nm = op_nm[i];
    end
    return expect_vec(r, nm);
  endfunction

  // Drive a word away from the edge and return just after the next posedge.
  task automatic drive(input logic [31:0] v);
    @(negedge clk);
    I = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [53:0] exp;
    reset = 1'b1;
    drive(32'h0C000C00);
`ifdef MIPS_CTRL_REG_EN
    exp = '0;
`else
    exp = expect_vec(1'b0, "jal");
`endif
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_hold I=%h got=%h expected=%h", I, got, exp);
    end
    reset = 1'b0;
    drive(32'h0C000C00);
    exp = expect_vec(1'b0, "jal");
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_release I=%h got=%h expected=%h", I, got, exp);
    end
  endtask

  task automatic test_directed;
    logic [31:0] vi [17] = '{32'h00000000, 32'h02328020, 32'h02328021, 32'h0232803F,
      32'h8C080004, 32'hAC080004, 32'hFC080004, 32'h04210010, 32'h04200010,
      32'h04300010, 32'h42000018, 32'h42000019, 32'h40086000, 32'h40886000,
      32'h0C000C00, 32'h03E00008, 32'h3C01ABCD};
    logic        vr [17] = '{1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,
      1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
    string       vn [17] = '{"sll","add","addu","","lw","sw","","bgez","bltz",
      "","eret","","mfc0","mtc0","jal","jr","lui"};
    logic [53:0] exp;
    for (int k = 0; k < 17; k++) begin
      drive(vi[k]);
      exp = expect_vec(vr[k], vn[k]);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL directed_%0d I=%h got=%h expected=%h", k, I, got, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] v;
    logic [53:0] exp;
    for (int k = 0; k < 1500; k++) begin
      v = $urandom;
      case ($urandom_range(0, 5))
        0: v[31:26] = 6'h00;
        1: begin v[31:26] = 6'h01; v[20:16] = 5'($urandom_range(0, 3)); end
        2: begin
             v[31:26] = 6'h10;
             v[25:21] = 5'($urandom_range(0, 5));
             if ($urandom_range(0, 3) == 0) v = 32'h42000018;
           end
        3: v[31:26] = op_code[$urandom_range(0, 21)];
        default: ;
      endcase
      drive(v);
      exp = model(v);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random_%0d I=%h got=%h expected=%h", k, I, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [53:0] exp;
    for (int k = 0; k < 26; k++) begin
      drive({6'h00, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), sp_fn[k]});
      exp = expect_vec(1'b1, sp_nm[k]);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_special_%s I=%h got=%h expected=%h", sp_nm[k], I, got, exp);
      end
    end
    for (int k = 0; k < 22; k++) begin
      drive({op_code[k], 26'($urandom)});
      exp = expect_vec(1'b0, op_nm[k]);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_op_%s I=%h got=%h expected=%h", op_nm[k], I, got, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    I     = 32'h0;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
